// File: rtl/cpu_bus_ctrl.sv
// Downstream bus controller for the 65832 core data bus.
// Routes each single-word core request to the external memory port,
// the internal 8-word I/O register bank, or unmapped space, and turns
// a non-responding memory access into a timeout error.
module cpu_bus_ctrl #(
    parameter int              DW       = 32,
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   MEM_BASE = 32'h0001_0000,
    parameter int              MEM_AW   = 16,
    parameter logic [AW-1:0]   IO_BASE  = 32'hFFFF_FF00,
    parameter int              TIMEOUT  = 15,
    parameter logic [DW-1:0]   ID_VALUE = 32'h6583_2001
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst_n,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [AW-1:0]     i_bus_addr,
    input  logic [DW-1:0]     i_bus_data,
    output logic [DW-1:0]     o_bus_data,
    output logic              o_bus_data_ready,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    input  logic [DW-1:0]     i_mem_rdata,
    input  logic              i_mem_ack,
    output logic [DW-1:0]     o_io_out,
    output logic [7:0]        o_timeout_count,
    output logic [7:0]        o_unmapped_count
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [DW-1:0]      io_reg_q [0:7];
    logic [DW-1:0]      data_d, wdata_d, io_rd;
    logic [MEM_AW-1:0]  addr_d;
    logic               ready_d, req_d, we_d, io_we;
    logic [7:0]         tcnt_d, ucnt_d;
    logic               mem_hit, io_hit;
    logic [2:0]         io_idx;

    // Address decode; memory takes priority over the I/O bank.
    always_comb begin
        mem_hit = (i_bus_addr[AW-1:MEM_AW] == MEM_BASE[AW-1:MEM_AW]);
        io_hit  = (i_bus_addr[AW-1:5] == IO_BASE[AW-1:5]);
        io_idx  = i_bus_addr[4:2];
        io_rd   = (io_idx == 3'd0) ? ID_VALUE : io_reg_q[io_idx];
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ready_d = 1'b0;
        data_d  = o_bus_data;
        req_d   = o_mem_req;
        we_d    = o_mem_we;
        addr_d  = o_mem_addr;
        wdata_d = o_mem_wdata;
        tcnt_d  = o_timeout_count;
        ucnt_d  = o_unmapped_count;
        io_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_bus_clk) begin
                    if (mem_hit) begin
                        req_d   = 1'b1;
                        we_d    = i_bus_we;
                        addr_d  = i_bus_addr[MEM_AW-1:0];
                        wdata_d = i_bus_data;
                        timer_d = '0;
                        state_d = MEM_WAIT;
                    end else if (io_hit) begin
                        // Register 0 is the read-only ID; writes to it are dropped.
                        io_we   = i_bus_we && (io_idx != 3'd0);
                        data_d  = i_bus_we ? '0 : io_rd;
                        ready_d = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        data_d  = '1;
                        if (o_unmapped_count != 8'hFF) ucnt_d = o_unmapped_count + 8'd1;
                        ready_d = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            MEM_WAIT: begin
                // An ack arriving on the final timeout cycle still completes normally.
                if (i_mem_ack) begin
                    req_d   = 1'b0;
                    data_d  = o_mem_we ? '0 : i_mem_rdata;
                    ready_d = 1'b1;
                    state_d = RELEASE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    data_d  = '1;
                    if (o_timeout_count != 8'hFF) tcnt_d = o_timeout_count + 8'd1;
                    ready_d = 1'b1;
                    state_d = RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RELEASE: begin
                // Wait for the core to drop its strobe so one request is served once.
                if (!i_bus_clk) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= IDLE;
            timer_q          <= '0;
            o_bus_data       <= '0;
            o_bus_data_ready <= 1'b0;
            o_mem_req        <= 1'b0;
            o_mem_we         <= 1'b0;
            o_mem_addr       <= '0;
            o_mem_wdata      <= '0;
            o_timeout_count  <= '0;
            o_unmapped_count <= '0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            o_bus_data       <= data_d;
            o_bus_data_ready <= ready_d;
            o_mem_req        <= req_d;
            o_mem_we         <= we_d;
            o_mem_addr       <= addr_d;
            o_mem_wdata      <= wdata_d;
            o_timeout_count  <= tcnt_d;
            o_unmapped_count <= ucnt_d;
        end
    end

    // I/O register bank; entry 0 is never written and reads as ID_VALUE.
    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) io_reg_q[i] <= '0;
        end else if (io_we) begin
            io_reg_q[io_idx] <= i_bus_data;
        end
    end

    assign o_io_out = io_reg_q[1];

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
Downstream bus controller for the 65832 CPU core's external data bus. It accepts single-word requests from the core (strobe, write-enable, 32-bit address/data). It decodes each request to one of three targets: the external memory port (request/ack handshake), an internal 8-word I/O register bank, or unmapped space. It returns read data with a one-cycle ready pulse, and converts non-responding memory accesses into timeout errors so the core never hangs.

Parameters:
DW, 32, data width (core bus width)
AW, 32, address width (core bus width)
MEM_BASE, 32'h0001_0000, memory window base; aligned to 2^MEM_AW
MEM_AW, 16, memory window size is 2^MEM_AW bytes; width of o_mem_addr
IO_BASE, 32'hFFFF_FF00, I/O bank base; 32-byte window
TIMEOUT, 15, max cycles o_mem_req waits for i_mem_ack (>=2)
ID_VALUE, 32'h6583_2001, read-only value of I/O reg 0

Ports:
i_cpu_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_bus_clk  in  1  core request strobe (level); addr/we/data stable while high
i_bus_we  in  1  1 = write, 0 = read
i_bus_addr  in  AW  byte address
i_bus_data  in  DW  write data from core
o_bus_data  out  DW  read data to core
o_bus_data_ready  out  1  one-cycle completion pulse
o_mem_req  out  1  memory request, held until ack or timeout
o_mem_we  out  1  memory write enable
o_mem_addr  out  MEM_AW  offset within memory window
o_mem_wdata  out  DW  memory write data
i_mem_rdata  in  DW  memory read data, valid with ack
i_mem_ack  in  1  memory completion, sampled only while o_mem_req=1
o_io_out  out  DW  live value of I/O reg 1 (LED/GPIO drive)
o_timeout_count  out  8  saturating count of memory timeouts
o_unmapped_count  out  8  saturating count of unmapped accesses

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; I/O regs 1..7 = 0; timer = 0; counters = 0. Reset mid-transaction aborts it immediately (o_mem_req drops, no ready pulse).
- All outputs are registered. States: IDLE, MEM_WAIT, RELEASE.
- Decode in IDLE (priority MEM > IO > unmapped):
  - MEM: addr[AW-1:MEM_AW] == MEM_BASE[AW-1:MEM_AW].
  - IO: addr[AW-1:5] == IO_BASE[AW-1:5]; index = addr[4:2]; addr[1:0] ignored.
- IDLE, i_bus_clk=0: hold; o_bus_data_ready=0.
- IDLE, i_bus_clk=1, MEM: o_mem_req<=1; o_mem_addr<=addr[MEM_AW-1:0]; o_mem_we and o_mem_wdata latched; timer<=0; go to MEM_WAIT.
- IDLE, i_bus_clk=1, IO:
  - Write to index 1..7 updates that reg at this edge; a write to index 0 is ignored.
  - Read returns the reg (index 0 = ID_VALUE); writes return o_bus_data=0.
  - o_bus_data_ready<=1; go to RELEASE. Latency: ready high in the cycle after the sampling edge.
- IDLE, i_bus_clk=1, unmapped: writes are dropped; o_bus_data<=all-ones; o_unmapped_count+1 (saturating at 255); ready<=1; go to RELEASE.
- MEM_WAIT:
  - i_mem_ack=1: o_mem_req<=0; o_bus_data<=i_mem_rdata (read) or 0 (write); ready<=1; go to RELEASE.
  - Else timer+1. When timer==TIMEOUT-1 with no ack: o_mem_req<=0; o_bus_data<=all-ones; o_timeout_count+1 (saturating); ready<=1; go to RELEASE. o_mem_req is therefore high for exactly TIMEOUT cycles.
  - Ack on the timeout cycle: ack wins and the counter is unchanged.
- RELEASE: ready<=0 (pulse is exactly one cycle). Return to IDLE on the first edge with i_bus_clk=0. A request held high is never serviced twice.
- Between transactions, o_bus_data holds its last value.
- i_mem_ack outside MEM_WAIT is ignored.
- o_io_out always equals I/O reg 1.

Test Plan:
- Reset then read 0xFFFF_FF00 -> ready pulse 1 cycle after strobe sampled, o_bus_data=0x6583_2001; write 0x1234 to same address -> reg 0 still reads ID.
- Write 0xA5 to 0xFFFF_FF04 -> o_io_out=0x0000_00A5 next cycle; read back 0xA5; strobe held 5 extra cycles -> only one ready pulse.
- Read 0x0001_0040, memory acks 3 cycles after o_mem_req rises with rdata 0xDEAD_BEEF -> o_mem_addr=0x0040, ready in the cycle after ack, o_bus_data=0xDEAD_BEEF, o_mem_req low.
- Read 0x0001_0000 with no ack -> o_mem_req high exactly 15 cycles, o_bus_data=0xFFFF_FFFF, o_timeout_count=1; repeat with ack on cycle 15 -> real data returned, count stays 1.
- Read 0x0000_8000 (unmapped) 300 times -> each returns 0xFFFF_FFFF, o_unmapped_count saturates at 255.
- Assert i_rst_n low during MEM_WAIT -> o_mem_req=0 and all outputs 0 immediately, no ready pulse; o_io_out=0 after release.
